// File: rtl/ts_sched_if.sv
// -----------------------------------------------------------------------------
// ts_sched_if
// Purpose : bundles the scheduler's gate-control, queue-FIFO and output-stage
//           signals so they can be passed as one port.
// Signals :
//   in_ts_schedule_valid [3:0]  per-queue schedulable pulse from gate control
//   in_ts_md_outport     [3:0]  per-queue egress port bit
//   in_ts_fifo_empty     [3:0]  per-queue packet FIFO empty
//   in_ts_q_data         [4*DW] per-queue show-ahead head word, Q0 in [DW-1:0]
//   out_ts_q_rden        [3:0]  one-hot FIFO pop
//   out_ts_q2_rden              one-cycle pulse per Q2 packet start
//   out_ts_data          [DW]   forwarded packet word
//   out_ts_data_wr              out_ts_data valid
//   out_ts_outport              egress port of the packet in flight
//   out_ts_pkt_done             one-cycle pulse after the last word
//   out_ts_err                  one-cycle error pulse
//
// Handshake: each queue FIFO is show-ahead. in_ts_q_data holds the head word
// whenever in_ts_fifo_empty is low. A word is consumed on a rising clk edge
// where out_ts_q_rden[i] is high; the FIFO must present the next word (or
// raise empty) by the following edge. out_ts_q_rden[i] is never high while
// in_ts_fifo_empty[i] is high. The output stage has no back-pressure: every
// cycle with out_ts_data_wr high carries exactly one word.
// -----------------------------------------------------------------------------
interface ts_sched_if #(
  parameter int DW = 134
);
  logic [3:0]      in_ts_schedule_valid;
  logic [3:0]      in_ts_md_outport;
  logic [3:0]      in_ts_fifo_empty;
  logic [4*DW-1:0] in_ts_q_data;
  logic [3:0]      out_ts_q_rden;
  logic            out_ts_q2_rden;
  logic [DW-1:0]   out_ts_data;
  logic            out_ts_data_wr;
  logic            out_ts_outport;
  logic            out_ts_pkt_done;
  logic            out_ts_err;

  // Gate control / FIFO / output-stage side.
  modport master (
    output in_ts_schedule_valid,
    output in_ts_md_outport,
    output in_ts_fifo_empty,
    output in_ts_q_data,
    input  out_ts_q_rden,
    input  out_ts_q2_rden,
    input  out_ts_data,
    input  out_ts_data_wr,
    input  out_ts_outport,
    input  out_ts_pkt_done,
    input  out_ts_err
  );

  // Scheduler side.
  modport slave (
    input  in_ts_schedule_valid,
    input  in_ts_md_outport,
    input  in_ts_fifo_empty,
    input  in_ts_q_data,
    output out_ts_q_rden,
    output out_ts_q2_rden,
    output out_ts_data,
    output out_ts_data_wr,
    output out_ts_outport,
    output out_ts_pkt_done,
    output out_ts_err
  );
endinterface

// File: rtl/ts_sched.sv
// -----------------------------------------------------------------------------
// ts_sched
// Purpose : transmit scheduler behind gate control. On a schedule_valid pulse it
//           picks one queue by strict priority (Q0 highest), then pops that
//           queue's show-ahead FIFO word by word up to EOP and forwards each
//           word to the output stage together with the queue's egress port.
//           Packets longer than MAX_PKT_WORDS are cut: the last forwarded word
//           gets EOP forced and the remainder stays in the FIFO.
// Ports   :
//   clk          clock
//   rst_n        asynchronous reset, active low
//   ts           ts_sched_if.slave bundle (see ts_sched_if)
//   dbg_state_o  current FSM state (0=IDLE, 1=XFER, 2=DONE)
// Word format: bit DW-1 = SOP, bit DW-2 = EOP.
// -----------------------------------------------------------------------------
module ts_sched #(
  parameter int DW            = 134,
  parameter int MAX_PKT_WORDS = 128   // 1..256
) (
  input  logic         clk,
  input  logic         rst_n,
  ts_sched_if.slave    ts,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // word_cnt counts words already forwarded, so the limit word is the one
  // popped while the count equals MAX_PKT_WORDS-1.
  localparam logic [7:0] LAST_IDX = 8'(MAX_PKT_WORDS - 1);

  state_e        state_q;
  logic [1:0]    sel_q;
  logic [7:0]    word_cnt_q;
  logic [7:0]    word_cnt_d;
  logic [DW-1:0] data_q;
  logic          wr_q;
  logic          outport_q;
  logic          q2_rden_q;
  logic          pkt_done_q;
  logic          err_q;

  logic [1:0]    pick;
  logic          pop;
  logic [DW-1:0] head_word;
  logic [DW-1:0] out_word;
  logic          head_sop;
  logic          head_eop;
  logic          first_word;
  logic          truncate;

  // Priority encoder: scanning from Q3 down leaves the lowest set index.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ts.in_ts_schedule_valid[i]) pick = 2'(i);
    end
  end

  // Head word of the selected queue.
  always_comb begin
    head_word = '0;
    case (sel_q)
      2'd0: head_word = ts.in_ts_q_data[0*DW +: DW];
      2'd1: head_word = ts.in_ts_q_data[1*DW +: DW];
      2'd2: head_word = ts.in_ts_q_data[2*DW +: DW];
      2'd3: head_word = ts.in_ts_q_data[3*DW +: DW];
      default: head_word = '0;
    endcase
  end

  assign head_sop   = head_word[DW-1];
  assign head_eop   = head_word[DW-2];
  assign first_word = (word_cnt_q == 8'd0);
  assign truncate   = (word_cnt_q == LAST_IDX) && !head_eop;

  // Pop whenever the selected FIFO has a word; an empty FIFO simply stalls.
  assign pop = (state_q == S_XFER) && !ts.in_ts_fifo_empty[sel_q];

  always_comb begin
    out_word = head_word;
    if (truncate) out_word[DW-2] = 1'b1;
  end

  // Saturating word counter.
  assign word_cnt_d = (word_cnt_q == 8'hFF) ? word_cnt_q : word_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      word_cnt_q <= 8'd0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      outport_q  <= 1'b0;
      q2_rden_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle below.
      q2_rden_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wr_q <= 1'b0;
          if (|ts.in_ts_schedule_valid) begin
            sel_q      <= pick;
            outport_q  <= ts.in_ts_md_outport[pick];
            word_cnt_q <= 8'd0;
            // gc charges Q2's token bucket once per scheduled packet.
            q2_rden_q  <= (pick == 2'd2);
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (pop) begin
            data_q     <= out_word;
            wr_q       <= 1'b1;
            word_cnt_q <= word_cnt_d;
            // A missing SOP is flagged but the word still goes out.
            err_q      <= (first_word && !head_sop) || truncate;
            if (head_eop || truncate) state_q <= S_DONE;
          end else begin
            wr_q <= 1'b0;
          end
        end
        S_DONE: begin
          wr_q       <= 1'b0;
          pkt_done_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ts.out_ts_q_rden   = pop ? (4'b0001 << sel_q) : 4'b0000;
  assign ts.out_ts_q2_rden  = q2_rden_q;
  assign ts.out_ts_data     = data_q;
  assign ts.out_ts_data_wr  = wr_q;
  assign ts.out_ts_outport  = outport_q;
  assign ts.out_ts_pkt_done = pkt_done_q;
  assign ts.out_ts_err      = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_ts_sched.sv
// -----------------------------------------------------------------------------
// tb_ts_sched
// Directed bench for ts_sched. Four show-ahead FIFO models feed the DUT; a
// monitor inside step() collects every forwarded word and counts the pulse
// outputs. Checks run at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ts_sched;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ts_sched_if #(.DW(DW)) ifc ();
  logic [1:0] dbg_state;

  ts_sched #(.DW(DW), .MAX_PKT_WORDS(MAXW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ts          (ifc.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- FIFO models and scoreboard ----------------
  logic [DW-1:0] fq [4][$];
  logic [3:0]    hold;
  logic [3:0]    pend;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            done_cnt, err_cnt, q2_cnt;
  logic [3:0]    rden_or;

  function automatic logic [DW-1:0] mk(input logic s, input logic e, input logic [13:0] pl);
    return {s, e, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      ifc.in_ts_fifo_empty[i] = (fq[i].size() == 0) || hold[i];
      ifc.in_ts_q_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    q2_cnt   = 0;
    rden_or  = '0;
  endtask

  // Called at a falling edge: one full clock, FIFO pops applied just after the
  // rising edge, outputs sampled at the next falling edge.
  task automatic step();
    #1;
    pend = ifc.out_ts_q_rden;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    refresh();
    @(negedge clk);
    if (ifc.out_ts_data_wr)  got_q.push_back(ifc.out_ts_data);
    if (ifc.out_ts_pkt_done) done_cnt++;
    if (ifc.out_ts_err)      err_cnt++;
    if (ifc.out_ts_q2_rden)  q2_cnt++;
    rden_or = rden_or | ifc.out_ts_q_rden;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_queue(input string tag);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rden"},  64'(ifc.out_ts_q_rden),   64'h0);
    chk({tag, "_q2"},    64'(ifc.out_ts_q2_rden),  64'h0);
    chk({tag, "_data"},  64'(ifc.out_ts_data),     64'h0);
    chk({tag, "_wr"},    64'(ifc.out_ts_data_wr),  64'h0);
    chk({tag, "_port"},  64'(ifc.out_ts_outport),  64'h0);
    chk({tag, "_done"},  64'(ifc.out_ts_pkt_done), 64'h0);
    chk({tag, "_err"},   64'(ifc.out_ts_err),      64'h0);
    chk({tag, "_state"}, 64'(dbg_state),           64'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ifc.in_ts_schedule_valid = '0;
    ifc.in_ts_md_outport     = '0;
    ifc.in_ts_fifo_empty     = '1;
    ifc.in_ts_q_data         = '0;
    hold = '0;
    pend = '0;
    refresh();
    clear_mon();

    // Reset values
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    step();

    // 1: Q0 3-word packet, port 1
    fq[0].push_back(mk(1'b1, 1'b0, 14'h101));
    fq[0].push_back(mk(1'b0, 1'b0, 14'h102));
    fq[0].push_back(mk(1'b0, 1'b1, 14'h103));
    ifc.in_ts_md_outport = 4'b0001;
    refresh();
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b0001;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    chk("t1_rden_t1", 64'(ifc.out_ts_q_rden), 64'h1);
    chk("t1_wr_t1",   64'(ifc.out_ts_data_wr), 64'h0);
    chk("t1_port",    64'(ifc.out_ts_outport), 64'h1);
    step();
    chk("t1_rden_t2", 64'(ifc.out_ts_q_rden), 64'h1);
    chk("t1_wr_t2",   64'(ifc.out_ts_data_wr), 64'h1);
    chk("t1_data_t2", 64'(ifc.out_ts_data), 64'(mk(1'b1, 1'b0, 14'h101)));
    step();
    chk("t1_data_t3", 64'(ifc.out_ts_data), 64'(mk(1'b0, 1'b0, 14'h102)));
    step();
    chk("t1_rden_t4", 64'(ifc.out_ts_q_rden), 64'h0);
    chk("t1_wr_t4",   64'(ifc.out_ts_data_wr), 64'h1);
    chk("t1_data_t4", 64'(ifc.out_ts_data), 64'(mk(1'b0, 1'b1, 14'h103)));
    chk("t1_state_t4", 64'(dbg_state), 64'h2);
    step();
    chk("t1_done_t5", 64'(ifc.out_ts_pkt_done), 64'h1);
    chk("t1_wr_t5",   64'(ifc.out_ts_data_wr), 64'h0);
    step();
    chk("t1_done_t6",  64'(ifc.out_ts_pkt_done), 64'h0);
    chk("t1_state_t6", 64'(dbg_state), 64'h0);
    chk("t1_q2_cnt",   64'(q2_cnt), 64'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 14'h101));
    exp_q.push_back(mk(1'b0, 1'b0, 14'h102));
    exp_q.push_back(mk(1'b0, 1'b1, 14'h103));
    check_queue("t1");

    // 2: valid=1110 picks Q1; Q2/Q3 loaded but untouched
    fq[1].push_back(mk(1'b1, 1'b0, 14'h201));
    fq[1].push_back(mk(1'b0, 1'b1, 14'h202));
    fq[2].push_back(mk(1'b1, 1'b0, 14'h301));
    fq[2].push_back(mk(1'b0, 1'b1, 14'h302));
    fq[3].push_back(mk(1'b1, 1'b0, 14'h401));
    fq[3].push_back(mk(1'b0, 1'b0, 14'h402));
    fq[3].push_back(mk(1'b0, 1'b0, 14'h403));
    fq[3].push_back(mk(1'b0, 1'b1, 14'h404));
    ifc.in_ts_md_outport = 4'b0100;
    refresh();
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b1110;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    chk("t2_rden_t1", 64'(ifc.out_ts_q_rden), 64'h2);
    chk("t2_port",    64'(ifc.out_ts_outport), 64'h0);
    run(5);
    chk("t2_rden_or", 64'(rden_or), 64'h2);
    chk("t2_done",    64'(done_cnt), 64'h1);
    chk("t2_q2_cnt",  64'(q2_cnt), 64'h0);
    chk("t2_q2_left", 64'(fq[2].size()), 64'h2);
    chk("t2_q3_left", 64'(fq[3].size()), 64'h4);
    exp_q.push_back(mk(1'b1, 1'b0, 14'h201));
    exp_q.push_back(mk(1'b0, 1'b1, 14'h202));
    check_queue("t2");

    // 3: Q2 2-word packet, q2_rden only at T+1
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b0100;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    chk("t3_q2_t1",   64'(ifc.out_ts_q2_rden), 64'h1);
    chk("t3_rden_t1", 64'(ifc.out_ts_q_rden), 64'h4);
    chk("t3_port",    64'(ifc.out_ts_outport), 64'h1);
    step();
    chk("t3_q2_t2",   64'(ifc.out_ts_q2_rden), 64'h0);
    run(4);
    chk("t3_q2_cnt",  64'(q2_cnt), 64'h1);
    chk("t3_done",    64'(done_cnt), 64'h1);
    chk("t3_err",     64'(err_cnt), 64'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 14'h301));
    exp_q.push_back(mk(1'b0, 1'b1, 14'h302));
    check_queue("t3");

    // 4: Q3 4-word packet with a 3-cycle empty gap after word 2
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b1000;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    chk("t4_rden_t1", 64'(ifc.out_ts_q_rden), 64'h8);
    chk("t4_port",    64'(ifc.out_ts_outport), 64'h0);
    step();
    step();
    hold[3] = 1'b1;
    refresh();
    step();
    chk("t4_gap1_wr",    64'(ifc.out_ts_data_wr), 64'h0);
    chk("t4_gap1_rden",  64'(ifc.out_ts_q_rden), 64'h0);
    chk("t4_gap1_state", 64'(dbg_state), 64'h1);
    step();
    chk("t4_gap2_wr",    64'(ifc.out_ts_data_wr), 64'h0);
    step();
    chk("t4_gap3_wr",    64'(ifc.out_ts_data_wr), 64'h0);
    hold[3] = 1'b0;
    refresh();
    run(4);
    chk("t4_done", 64'(done_cnt), 64'h1);
    chk("t4_err",  64'(err_cnt), 64'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 14'h401));
    exp_q.push_back(mk(1'b0, 1'b0, 14'h402));
    exp_q.push_back(mk(1'b0, 1'b0, 14'h403));
    exp_q.push_back(mk(1'b0, 1'b1, 14'h404));
    check_queue("t4");

    // 5: Q0 stream without EOP, truncated at MAXW=4 words
    fq[0].push_back(mk(1'b1, 1'b0, 14'h501));
    for (int i = 2; i <= 6; i++) fq[0].push_back(mk(1'b0, 1'b0, 14'(14'h500 + i)));
    ifc.in_ts_md_outport = 4'b0000;
    refresh();
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b0001;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    run(7);
    chk("t5_err",   64'(err_cnt), 64'h1);
    chk("t5_done",  64'(done_cnt), 64'h1);
    chk("t5_state", 64'(dbg_state), 64'h0);
    chk("t5_left",  64'(fq[0].size()), 64'h2);
    exp_q.push_back(mk(1'b1, 1'b0, 14'h501));
    exp_q.push_back(mk(1'b0, 1'b0, 14'h502));
    exp_q.push_back(mk(1'b0, 1'b0, 14'h503));
    exp_q.push_back(mk(1'b0, 1'b1, 14'h504));
    check_queue("t5");
    fq[0].delete();
    refresh();

    // 6: reset during word 2 of a 5-word Q1 packet, then a new packet
    for (int i = 1; i <= 5; i++) fq[1].push_back(mk(i == 1, i == 5, 14'(14'h600 + i)));
    ifc.in_ts_md_outport = 4'b0010;
    refresh();
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b0010;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    step();
    chk("t6_port_pre", 64'(ifc.out_ts_outport), 64'h1);
    #1;
    pend = ifc.out_ts_q_rden;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    end
    refresh();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fq[1].delete();
    // New packet whose first word lacks SOP: flagged, still forwarded.
    fq[0].push_back(mk(1'b0, 1'b0, 14'h701));
    fq[0].push_back(mk(1'b0, 1'b1, 14'h702));
    ifc.in_ts_md_outport = 4'b0001;
    refresh();
    clear_mon();
    ifc.in_ts_schedule_valid = 4'b0001;
    step();
    ifc.in_ts_schedule_valid = 4'b0000;
    chk("t6_rden_t1", 64'(ifc.out_ts_q_rden), 64'h1);
    chk("t6_port",    64'(ifc.out_ts_outport), 64'h1);
    run(5);
    chk("t6_err",  64'(err_cnt), 64'h1);
    chk("t6_done", 64'(done_cnt), 64'h1);
    exp_q.push_back(mk(1'b0, 1'b0, 14'h701));
    exp_q.push_back(mk(1'b0, 1'b1, 14'h702));
    check_queue("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
